// File: rtl/nxn_window_filter_if.sv
// Pixel stream bundle for nxn_window_filter: the raw stream going in and the
// filtered stream coming back out, both in valid/blanking format.
interface nxn_window_filter_if #(
  parameter int DATA_WIDTH = 8
);
  // Valid-only streaming: a pixel transfers on every clock where its valid is
  // high; there is no ready, so each side must accept one pixel per cycle.
  logic                  sof;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] din;
  logic                  validin;
  logic                  blanking_in;
  logic [DATA_WIDTH-1:0] dout;
  logic                  validout;
  logic                  blanking_out;
  logic                  overflow;

  modport master (
    output sof, mode, din, validin, blanking_in,
    input  dout, validout, blanking_out, overflow
  );

  modport slave (
    input  sof, mode, din, validin, blanking_in,
    output dout, validout, blanking_out, overflow
  );
endinterface

// File: rtl/nxn_window_filter.sv
// WIN x WIN sliding-window filter (bypass / box mean / max / min) over a
// line-buffered pixel stream, three pipeline stages, one pixel per cycle.
module nxn_window_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN        = 5,
  parameter int LINE_WIDTH = 320
) (
  input logic                clock,
  input logic                reset,
  nxn_window_filter_if.slave bus
);
  localparam int H     = (WIN - 1) / 2;
  localparam int B     = 2 * H;
  localparam int SW    = DATA_WIDTH + 6;
  localparam int PW    = SW + 17;
  localparam int CW    = $clog2(LINE_WIDTH + 1);
  localparam int AW    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int RW    = $clog2(B + 1);
  localparam int RECIP = (65536 + (WIN * WIN) / 2) / (WIN * WIN);
  localparam logic [PW-1:0] MAXV = PW'(2 ** DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_MEAN   = 2'd1,
    MODE_MAX    = 2'd2,
    MODE_MIN    = 2'd3
  } mode_e;

  mode_e           mode_q, pix_mode, s1_mode, s2_mode;
  logic [CW-1:0]   col_q, pix_col, col_after, col_d;
  logic [RW-1:0]   row_q, pix_row, row_d;
  logic [AW-1:0]   addr;
  logic            blank_q, store, line_end, border, ovf_q;
  logic            s1_valid, s1_zero, s2_valid, s2_zero;
  logic [2:0]      blank_pipe;

  // sof rewinds the counters for the very pixel it accompanies.
  always_comb begin
    pix_col   = bus.sof ? '0 : col_q;
    pix_row   = bus.sof ? '0 : row_q;
    pix_mode  = bus.sof ? mode_e'(bus.mode) : mode_q;
    addr      = pix_col[AW-1:0];
    store     = bus.validin && (pix_col < CW'(LINE_WIDTH));
    border    = (pix_row < RW'(B)) || (pix_col < CW'(B));
    col_after = store ? pix_col + CW'(1) : pix_col;
    line_end  = bus.blanking_in && !blank_q && (col_after != '0);
    col_d     = line_end ? '0 : col_after;
    row_d     = pix_row;
    if (line_end && (pix_row != RW'(B))) row_d = pix_row + RW'(1);
  end

  logic [DATA_WIDTH-1:0] lb      [WIN-1][LINE_WIDTH];
  logic [DATA_WIDTH-1:0] col_vec [WIN];
  logic [DATA_WIDTH-1:0] win     [WIN][WIN];

  // col_vec[k] is the pixel k rows above the incoming one in this column.
  always_comb begin
    col_vec[0] = bus.din;
    for (int k = 1; k < WIN; k++) col_vec[k] = lb[k-1][addr];
  end

  // Line buffers and window are never cleared; row restarting at 0 masks them.
  always_ff @(posedge clock) begin
    if (store) begin
      for (int k = 0; k < WIN - 1; k++) lb[k][addr] <= col_vec[k];
      for (int i = 0; i < WIN; i++) begin
        win[i][0] <= col_vec[i];
        for (int j = 1; j < WIN; j++) win[i][j] <= win[i][j-1];
      end
    end
  end

  logic [SW-1:0] row_sel [WIN];
  logic [SW-1:0] s2_row  [WIN];
  logic [DATA_WIDTH-1:0] s2_centre;

  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      logic [SW-1:0]         acc;
      logic [DATA_WIDTH-1:0] mx;
      logic [DATA_WIDTH-1:0] mn;
      acc = '0;
      mx  = '0;
      mn  = '1;
      for (int j = 0; j < WIN; j++) begin
        acc = acc + SW'(win[i][j]);
        if (win[i][j] > mx) mx = win[i][j];
        if (win[i][j] < mn) mn = win[i][j];
      end
      case (s1_mode)
        MODE_MEAN: row_sel[i] = acc;
        MODE_MAX:  row_sel[i] = SW'(mx);
        default:   row_sel[i] = SW'(mn);
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < WIN; i++) s2_row[i] <= row_sel[i];
    s2_centre <= win[H][H];
  end

  logic [SW-1:0]         tot_sum, tot_max, tot_min;
  logic [PW-1:0]         mean_full;
  logic [DATA_WIDTH-1:0] result;

  always_comb begin
    tot_sum = '0;
    tot_max = '0;
    tot_min = '1;
    for (int i = 0; i < WIN; i++) begin
      tot_sum = tot_sum + s2_row[i];
      if (s2_row[i] > tot_max) tot_max = s2_row[i];
      if (s2_row[i] < tot_min) tot_min = s2_row[i];
    end
    mean_full = (PW'(tot_sum) * PW'(RECIP)) >> 16;
    case (s2_mode)
      MODE_BYPASS: result = s2_centre;
      MODE_MEAN:   result = (mean_full > MAXV) ? MAXV[DATA_WIDTH-1:0]
                                               : mean_full[DATA_WIDTH-1:0];
      MODE_MAX:    result = tot_max[DATA_WIDTH-1:0];
      default:     result = tot_min[DATA_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= MODE_BYPASS;
      blank_q      <= 1'b0;
      ovf_q        <= 1'b0;
      s1_valid     <= 1'b0;
      s1_zero      <= 1'b0;
      s1_mode      <= MODE_BYPASS;
      s2_valid     <= 1'b0;
      s2_zero      <= 1'b0;
      s2_mode      <= MODE_BYPASS;
      blank_pipe   <= '0;
      bus.dout     <= '0;
      bus.validout <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      blank_q <= bus.blanking_in;
      if (bus.sof) mode_q <= mode_e'(bus.mode);
      if (bus.validin && !store) ovf_q <= 1'b1;
      else if (bus.sof)          ovf_q <= 1'b0;
      s1_valid     <= bus.validin;
      s1_zero      <= border || !store;
      s1_mode      <= pix_mode;
      s2_valid     <= s1_valid;
      s2_zero      <= s1_zero;
      s2_mode      <= s1_mode;
      blank_pipe   <= {blank_pipe[1:0], bus.blanking_in};
      bus.dout     <= (s2_valid && !s2_zero) ? result : '0;
      bus.validout <= s2_valid;
    end
  end

  assign bus.blanking_out = blank_pipe[2];
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_nxn_window_filter.sv
// Directed bench for nxn_window_filter at WIN=3, LINE_WIDTH=8: each scenario
// drives frames and compares the captured output stream against hand values.
module tb_nxn_window_filter;
  localparam int DW  = 8;
  localparam int WIN = 3;
  localparam int LW  = 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  nxn_window_filter_if #(.DATA_WIDTH(DW)) bus ();

  nxn_window_filter #(
    .DATA_WIDTH(DW),
    .WIN       (WIN),
    .LINE_WIDTH(LW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int            in_cyc  [$];
  int            got_cyc [$];
  logic [DW-1:0] frame [8][10];
  bit            bin_hist  [4096];
  bit            bout_hist [4096];

  always @(posedge clock) cyc <= cyc + 1;

  // output capture, sampled mid-cycle
  always @(negedge clock) begin
    if (reset && bus.validout) begin
      got_q.push_back(bus.dout);
      got_cyc.push_back(cyc);
    end
    if (cyc < 4096) begin
      bin_hist[cyc]  = bus.blanking_in;
      bout_hist[cyc] = bus.blanking_out;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive_cycle(input bit v, input bit s, input bit b, input logic [DW-1:0] d);
    @(posedge clock);
    #1;
    bus.validin     = v;
    bus.sof         = s;
    bus.blanking_in = b;
    bus.din         = d;
    if (v) in_cyc.push_back(cyc);
  endtask

  task automatic drive_blank();
    drive_cycle(1'b0, 1'b0, 1'b1, '0);
    drive_cycle(1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic drive_line(input int r, input int n, input bit first);
    for (int c = 0; c < n; c++) drive_cycle(1'b1, first && (c == 0), 1'b0, frame[r][c]);
    drive_blank();
  endtask

  task automatic drive_frame(input int nrows);
    for (int r = 0; r < nrows; r++) drive_line(r, 8, r == 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    in_cyc.delete();
    got_cyc.delete();
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++) frame[r][c] = DW'(8 * r + c);
  endtask

  task automatic fill_const(input logic [DW-1:0] v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++) frame[r][c] = v;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.validin = 1'b0; bus.sof = 1'b0; bus.blanking_in = 1'b0; bus.din = '0; bus.mode = 2'd0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (bus.dout !== 8'd0)      begin bad++; $display("FAIL reset_dout got=%0d exp=0", bus.dout); end
    total++; if (bus.validout !== 1'b0)  begin bad++; $display("FAIL reset_validout got=%0b exp=0", bus.validout); end
    total++; if (bus.blanking_out !== 1'b0) begin bad++; $display("FAIL reset_blanking_out got=%0b exp=0", bus.blanking_out); end
    total++; if (bus.overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%0b exp=0", bus.overflow); end
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    total++; if (bus.validout !== 1'b0)  begin bad++; $display("FAIL reset_release_validout got=%0b exp=0", bus.validout); end
  endtask

  task automatic test_bypass();
    int start, stop;
    fill_ramp();
    bus.mode = 2'd0;
    clear_q();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp_q.push_back((r < 2 || c < 2) ? 8'd0 : DW'(8 * (r - 1) + (c - 1)));
    start = cyc;
    drive_frame(8);
    drain();
    stop = cyc;
    total++;
    if (got_q.size() != 64) begin bad++; $display("FAIL bypass_count got=%0d exp=64", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bypass_pix[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
    for (int i = 0; i < got_cyc.size() && i < in_cyc.size(); i++) begin
      total++;
      if (got_cyc[i] - in_cyc[i] !== 3) begin bad++; $display("FAIL bypass_latency[%0d] got=%0d exp=3", i, got_cyc[i] - in_cyc[i]); end
    end
    for (int k = start + 3; k < stop && k < 4096; k++) begin
      total++;
      if (bout_hist[k] !== bin_hist[k-3]) begin bad++; $display("FAIL blanking_align[%0d] got=%0b exp=%0b", k, bout_hist[k], bin_hist[k-3]); end
    end
  endtask

  task automatic test_mean();
    for (int p = 0; p < 3; p++) begin
      if (p == 0) fill_const(8'd200);
      else if (p == 1) fill_const(8'd255);
      else
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 10; c++) frame[r][c] = ((r + c) % 2 == 1) ? 8'd90 : 8'd0;
      bus.mode = 2'd1;
      clear_q();
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          if (r < 2 || c < 2)  exp_q.push_back(8'd0);
          else if (p == 0)     exp_q.push_back(8'd200);
          else if (p == 1)     exp_q.push_back(8'd255);
          else                 exp_q.push_back((frame[r-1][c-1] == 8'd90) ? 8'd50 : 8'd40);
        end
      drive_frame(8);
      drain();
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL mean%0d_count got=%0d exp=%0d", p, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL mean%0d_pix[%0d] got=%0d exp=%0d", p, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_max_min();
    for (int p = 0; p < 2; p++) begin
      fill_const((p == 0) ? 8'd0 : 8'd255);
      frame[3][3] = (p == 0) ? 8'd255 : 8'd0;
      bus.mode = (p == 0) ? 2'd2 : 2'd3;
      clear_q();
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          if (r < 2 || c < 2) exp_q.push_back(8'd0);
          else if (r >= 3 && r <= 5 && c >= 3 && c <= 5) exp_q.push_back((p == 0) ? 8'd255 : 8'd0);
          else exp_q.push_back((p == 0) ? 8'd0 : 8'd255);
        end
      drive_frame(8);
      drain();
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL spike%0d_count got=%0d exp=%0d", p, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL spike%0d_pix[%0d] got=%0d exp=%0d", p, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_overflow();
    fill_ramp();
    frame[3][8] = 8'd77;
    frame[3][9] = 8'd77;
    bus.mode = 2'd0;
    clear_q();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < ((r == 3) ? 10 : 8); c++)
        exp_q.push_back((r < 2 || c < 2 || c >= 8) ? 8'd0 : DW'(8 * (r - 1) + (c - 1)));
    for (int r = 0; r < 3; r++) drive_line(r, 8, r == 0);
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, frame[3][c]);
      @(negedge clock);
      if (c == 8) begin
        total++;
        if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%0b exp=0", bus.overflow); end
      end
      if (c == 9) begin
        total++;
        if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_after got=%0b exp=1", bus.overflow); end
      end
    end
    drive_blank();
    for (int r = 4; r < 8; r++) drive_line(r, 8, 1'b0);
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_pix[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", bus.overflow); end
    // a fresh frame clears the flag
    clear_q();
    drive_cycle(1'b1, 1'b1, 1'b0, frame[0][0]);
    drive_cycle(1'b1, 1'b0, 1'b0, frame[0][1]);
    @(negedge clock);
    total++;
    if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_sof got=%0b exp=0", bus.overflow); end
    for (int c = 2; c < 8; c++) drive_cycle(1'b1, 1'b0, 1'b0, frame[0][c]);
    drive_blank();
    for (int c = 0; c < 8; c++) exp_q.push_back(8'd0);
    drain();
    total++;
    if (got_q.size() != 8) begin bad++; $display("FAIL ovf_next_frame_count got=%0d exp=8", got_q.size()); end
  endtask

  task automatic test_mode_latch();
    fill_ramp();
    bus.mode = 2'd0;
    clear_q();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp_q.push_back((r < 2 || c < 2) ? 8'd0 : DW'(8 * (r - 1) + (c - 1)));
    for (int r = 0; r < 4; r++) drive_line(r, 8, r == 0);
    bus.mode = 2'd2;
    for (int r = 4; r < 8; r++) drive_line(r, 8, 1'b0);
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL latch_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL latch_hold_pix[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
    // next frame takes max mode: ramp window max is its bottom-right pixel
    clear_q();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp_q.push_back((r < 2 || c < 2) ? 8'd0 : DW'(8 * r + c));
    drive_frame(8);
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL latch_max_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL latch_max_pix[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++) frame[r][c] = DW'(255 - (8 * r + c));
    bus.mode = 2'd0;
    clear_q();
    for (int r = 0; r < 4; r++) drive_line(r, 8, r == 0);
    for (int c = 0; c < 4; c++) drive_cycle(1'b1, 1'b0, 1'b0, frame[4][c]);
    @(posedge clock);
    #2;
    reset = 1'b0;
    bus.validin = 1'b0;
    bus.sof = 1'b0;
    #1;
    total++; if (bus.dout !== 8'd0)         begin bad++; $display("FAIL midreset_dout got=%0d exp=0", bus.dout); end
    total++; if (bus.validout !== 1'b0)     begin bad++; $display("FAIL midreset_validout got=%0b exp=0", bus.validout); end
    total++; if (bus.blanking_out !== 1'b0) begin bad++; $display("FAIL midreset_blanking_out got=%0b exp=0", bus.blanking_out); end
    total++; if (bus.overflow !== 1'b0)     begin bad++; $display("FAIL midreset_overflow got=%0b exp=0", bus.overflow); end
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    clear_q();
    fill_ramp();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp_q.push_back((r < 2 || c < 2) ? 8'd0 : DW'(8 * (r - 1) + (c - 1)));
    drive_frame(8);
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL midreset_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL midreset_pix[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  // final report
  initial begin
    test_reset();
    test_bypass();
    test_mean();
    test_max_min();
    test_overflow();
    test_mode_latch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
